mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/arb_watchdog.sv | 39 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the
// default watchdog limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for the memory arbiter; flags an access that has waited
// TIMEOUT cycles without an acknowledge.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Fires in the TIMEOUT-th busy cycle, so the count reaches TIMEOUT on that edge.
    assign expire_o = busy_i && !ack_i && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (busy_i && !ack_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: single-port memory shared by fetch and data requesters,
// data has fixed priority. Optional timeout abort enabled by ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err
);

    arb_state_t        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              d_ready_q,   d_ready_d;
    logic              d_any;
    logic              expire;

    assign d_any = d_rd_en | d_wr_en;

`ifdef ARB_TIMEOUT_EN
    logic grant;
    logic busy;
    logic err_q;

    assign grant = (state_q == IDLE) && (d_any || if_req);
    assign busy  = (state_q == D_BUSY) || (state_q == I_BUSY);

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (grant),
        .busy_i   (busy),
        .ack_i    (mem_ack),
        .expire_o (expire)
    );

    // Aborts always land in DONE, so err lines up with the ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= busy && expire;
        end
    end

    assign err = err_q;
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_any) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr_en;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_req) begin
                    state_d     = I_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            D_BUSY: begin
                if (mem_ack || expire) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    // Write completions leave the load data register untouched.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end
            end
            I_BUSY: begin
                if (mem_ack || expire) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = mem_ack ? mem_rdata : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

    assign stall = (d_any & ~d_ready_q) | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expectations,
// a negedge monitor pops and compares them as the DUT responds.
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          hold;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rdy_exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          delay;
        bit          spurious;
    } rsp_t;

    mem_exp_t exp_mem_q[$];
    rdy_exp_t exp_d_q[$];
    rdy_exp_t exp_if_q[$];
    rsp_t     rsp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit late_ack = 0;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_rd_en   (d_rd_en),
        .d_wr_en   (d_wr_en),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_rdy(input bit is_d, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (is_d ? d_ready : if_ready) begin
                at_cyc = cyc;
                return;
            end
        end
        chk(is_d ? "d_ready_wait" : "if_ready_wait", is_d ? d_ready : if_ready, 1);
    endtask

    // Memory responder: acks after rsp.delay extra cycles of mem_req.
    initial begin
        rsp_t cur;
        bit   active;
        bit   spur;
        int   cnt;
        active    = 0;
        spur      = 0;
        cnt       = 0;
        cur.rdata = '0;
        cur.delay = 1000;
        cur.spurious = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (late_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
                late_ack  = 0;
            end else if (spur) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hFFFFFFFF;
                spur      = 0;
            end else if (mem_req) begin
                if (!active) begin
                    if (rsp_q.size() == 0) begin
                        cur.rdata = '0;
                        cur.delay = 1000;
                        cur.spurious = 0;
                    end else begin
                        cur = rsp_q.pop_front();
                    end
                    active = 1;
                    cnt    = 0;
                end
                if (cnt == cur.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rdata;
                    spur      = cur.spurious;
                end else begin
                    cnt++;
                end
            end
            if (!mem_req) active = 0;
        end
    end

    // Monitor
    initial begin
        mem_exp_t me;
        rdy_exp_t re;
        bit       trk;
        int       held;
        logic     prev_d;
        logic     prev_if;
        trk = 0;
        held = 0;
        prev_d = 1'b0;
        prev_if = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                trk = 0;
                prev_d = 1'b0;
                prev_if = 1'b0;
            end else begin
                chk("stall", stall, ((d_rd_en | d_wr_en) & ~d_ready) | (if_req & ~if_ready));
                if (mem_req) begin
                    if (!trk) begin
                        if (exp_mem_q.size() == 0) begin
                            chk("unexpected_mem_req", mem_req, 0);
                        end else begin
                            me = exp_mem_q.pop_front();
                            chk("mem_addr", mem_addr, me.addr);
                            chk("mem_we", mem_we, me.we);
                            chk("mem_wdata", mem_wdata, me.wdata);
                            trk = 1;
                            held = 1;
                        end
                    end else begin
                        held++;
                        chk("mem_addr_stable", mem_addr, me.addr);
                        chk("mem_we_stable", mem_we, me.we);
                        chk("mem_wdata_stable", mem_wdata, me.wdata);
                    end
                end else if (trk) begin
                    chk("mem_req_hold_cycles", held, me.hold);
                    trk = 0;
                end
                if (d_ready) begin
                    chk("d_ready_width", prev_d, 0);
                    if (exp_d_q.size() == 0) begin
                        chk("unexpected_d_ready", d_ready, 0);
                    end else begin
                        re = exp_d_q.pop_front();
                        chk("d_rdata", d_rdata, re.rdata);
                        chk("d_err", err, re.err);
                    end
                end
                if (if_ready) begin
                    chk("if_ready_width", prev_if, 0);
                    if (exp_if_q.size() == 0) begin
                        chk("unexpected_if_ready", if_ready, 0);
                    end else begin
                        re = exp_if_q.pop_front();
                        chk("if_rdata", if_rdata, re.rdata);
                        chk("if_err", err, re.err);
                    end
                end
                if (!d_ready && !if_ready) chk("err_without_ready", err, 0);
                prev_d = d_ready;
                prev_if = if_ready;
            end
        end
    end

    // Stimulus
    initial begin
        int t0;
        int t1;
        int t2;
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        d_rd_en = 1'b0;
        d_wr_en = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);

        // Single load
        rsp_q.push_back('{32'hDEADBEEF, 0, 0});
        exp_mem_q.push_back('{32'h40, 1'b0, 32'h0, 1});
        exp_d_q.push_back('{32'hDEADBEEF, 1'b0});
        @(posedge clk); #1;
        d_rd_en = 1'b1; d_addr = 32'h40; t0 = cyc;
        #1 chk("load_stall_pending", stall, 1);
        wait_rdy(1, t1);
        chk("load_latency", t1 - t0, 2);
        chk("load_stall_at_ready", stall, 0);
        d_rd_en = 1'b0;

        // Contention: write beats fetch
        rsp_q.push_back('{32'h99999999, 0, 0});
        rsp_q.push_back('{32'hCAFEF00D, 0, 0});
        exp_mem_q.push_back('{32'h80, 1'b1, 32'h12345678, 1});
        exp_mem_q.push_back('{32'h100, 1'b0, 32'h0, 1});
        exp_d_q.push_back('{32'hDEADBEEF, 1'b0});
        exp_if_q.push_back('{32'hCAFEF00D, 1'b0});
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        d_wr_en = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
        wait_rdy(1, t1);
        d_wr_en = 1'b0; d_wdata = '0;
        wait_rdy(0, t2);
        if_req = 1'b0;
        chk("fetch_after_write_gap_ge3", (t2 - t1) >= 3, 1);

        // Wait states plus spurious ack in DONE
        rsp_q.push_back('{32'h55AA55AA, 4, 1});
        exp_mem_q.push_back('{32'h200, 1'b0, 32'h0, 5});
        exp_d_q.push_back('{32'h55AA55AA, 1'b0});
        @(posedge clk); #1;
        d_rd_en = 1'b1; d_addr = 32'h200; t0 = cyc;
        wait_rdy(1, t1);
        d_rd_en = 1'b0;
        chk("waitstate_latency", t1 - t0, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("waitstate_d_rdata_hold", d_rdata, 32'h55AA55AA);
        chk("waitstate_mem_req_idle", mem_req, 0);

        // Reset mid-access, late ack afterwards
        rsp_q.push_back('{32'h0, 1000, 0});
        @(posedge clk); #1;
        d_rd_en = 1'b1; d_addr = 32'h44;
        @(posedge clk); #1;
        chk("rstmid_busy_mem_req", mem_req, 1);
        chk("rstmid_busy_mem_addr", mem_addr, 32'h44);
        rst = 1'b1; d_rd_en = 1'b0;
        @(negedge clk);
        late_ack = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_d_rdata", d_rdata, 0);
        chk("rstmid_late_ack_seen", mem_ack, 1);
        @(posedge clk); #1;
        chk("rstmid_after_ack_mem_req", mem_req, 0);
        chk("rstmid_after_ack_d_ready", d_ready, 0);
        chk("rstmid_after_ack_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        chk("rstmid_idle_mem_req", mem_req, 0);

        // Back-to-back loads with request held
        rsp_q.push_back('{32'h11111111, 0, 0});
        rsp_q.push_back('{32'h22222222, 0, 0});
        exp_mem_q.push_back('{32'h300, 1'b0, 32'h0, 1});
        exp_mem_q.push_back('{32'h304, 1'b0, 32'h0, 1});
        exp_d_q.push_back('{32'h11111111, 1'b0});
        exp_d_q.push_back('{32'h22222222, 1'b0});
        @(posedge clk); #1;
        d_rd_en = 1'b1; d_addr = 32'h300; t0 = cyc;
        wait_rdy(1, t1);
        chk("b2b_first_latency", t1 - t0, 2);
        d_addr = 32'h304;
        wait_rdy(1, t2);
        chk("b2b_second_period", t2 - t1, 3);
        d_rd_en = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Fetch that never gets an ack
        rsp_q.push_back('{32'h0, 1000, 0});
        exp_mem_q.push_back('{32'h500, 1'b0, 32'h0, 4});
        exp_if_q.push_back('{32'h0, 1'b1});
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h500; t0 = cyc;
        wait_rdy(0, t1);
        chk("timeout_latency", t1 - t0, 5);
        chk("timeout_err", err, 1);
        chk("timeout_if_rdata", if_rdata, 0);
        if_req = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("left_mem_exp", exp_mem_q.size(), 0);
        chk("left_d_exp", exp_d_q.size(), 0);
        chk("left_if_exp", exp_if_q.size(), 0);
        chk("left_rsp", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
